lsu: RTL

Load/store unit sitting directly downstream of the instruction decoder and ALU. It takes a memory operation (address from the ALU, store data from rs2, size/sign from funct3, direction from the decoder's LSU write-enable) and runs it on a single-outstanding req/ack data-memory bus. It stalls the core until the access completes and returns the aligned, extended load result for write-back. Misaligned, illegal and timed-out accesses are reported without corrupting memory.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
// FSM states, error codes, funct3 encodings and legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] LSU_ERR_OK  = 2'b00;
  localparam logic [1:0] LSU_ERR_MIS = 2'b01;
  localparam logic [1:0] LSU_ERR_TO  = 2'b10;
  localparam logic [1:0] LSU_ERR_ILL = 2'b11;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic f3_legal(input logic we,
                                    input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B),
      (f3 == F3_H),
      (f3 == F3_W):  ok = 1'b1;
      (f3 == F3_BU),
      (f3 == F3_HU): ok = !we;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (f3[1:0] == 2'd1): bad = off[0];
      (f3[1:0] == 2'd2): bad = (off != 2'd0);
      default:           bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication / byte enables and
// load shift with sign or zero extension.
import lsu_pkg::*;

module lsu_align (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_be,
  output logic [31:0] load_data
);

  logic [31:0] sh;

  // store lanes and byte enables; loads read the whole word
  always_comb begin
    lane_wdata = wdata;
    lane_be    = 4'hf;
    case (funct3[1:0])
      2'd0: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_be    = 4'b0001 << off;
      end
      2'd1: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_be    = 4'b0011 << off;
      end
      default: begin
        lane_wdata = wdata;
        lane_be    = 4'hf;
      end
    endcase
    if (!we) lane_be = 4'hf;
  end

  // load extraction from the addressed byte lane
  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_data = {24'd0, sh[7:0]};
      F3_HU:   load_data = {16'd0, sh[15:0]};
      default: load_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with req/ack bus,
// stall generation, alignment errors and ack timeout.
import lsu_pkg::*;

module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ?
                      CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        idle;
  logic        a_we;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] load_data;

  assign idle  = (state == IDLE);
  assign a_we  = idle ? i_we : we_q;
  assign a_f3  = idle ? i_funct3 : f3_q;
  assign a_off = idle ? i_addr[1:0] : off_q;

  assign o_stall = !i_rst &&
                   ((idle && i_valid) || (state == BUSY));

  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_f3),
    .off        (a_off),
    .wdata      (i_wdata),
    .rdata      (i_mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_be    (lane_be),
    .load_data  (load_data)
  );

  // control FSM with registered bus and result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      o_done      <= 1'b0;
      o_err       <= LSU_ERR_OK;
      o_rdata     <= 32'd0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_be    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          o_err  <= LSU_ERR_OK;
          if (i_valid) begin
            if (!f3_legal(i_we, i_funct3)) begin
              o_err   <= LSU_ERR_ILL;
              o_rdata <= 32'd0;
              o_done  <= 1'b1;
              state   <= RESP;
            end else if (misaligned(i_funct3, i_addr[1:0])) begin
              o_err   <= LSU_ERR_MIS;
              o_rdata <= 32'd0;
              o_done  <= 1'b1;
              state   <= RESP;
            end else begin
              we_q        <= i_we;
              f3_q        <= i_funct3;
              off_q       <= i_addr[1:0];
              cnt         <= '0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_we;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wdata <= lane_wdata;
              o_mem_be    <= lane_be;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_rdata   <= we_q ? 32'd0 : load_data;
            o_err     <= LSU_ERR_OK;
            o_done    <= 1'b1;
            state     <= RESP;
          end else if (TO_EN && cnt == TLAST) begin
            o_mem_req <= 1'b0;
            o_rdata   <= 32'd0;
            o_err     <= LSU_ERR_TO;
            o_done    <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          o_done <= 1'b0;
          o_err  <= LSU_ERR_OK;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
